// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the non-power-of-two synchronous FIFO.
// The read mode is chosen by SYNC_FIFO_FWFT_EN; see sync_fifo_non2n_param.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 520;

  // What the FIFO does with its count on a given cycle.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Bits needed to hold values 0..value-1. Never returns less than 1, so a
  // two-entry FIFO still gets a one-bit pointer.
  function automatic int clog2_width(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem_non2n.sv
// FIFO_DEPTH x DATA_WIDTH storage with one write port and one read port.
// Read is registered by default, asynchronous when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem_non2n
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_WIDTH = clog2_width(FIFO_DEPTH)
) (
  input  logic                  clk,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic                  rst,
  input  logic                  rd_en,
`endif
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // NOTE: the array has no reset; stale words are unreachable because the
  // pointers and count are reset, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem[raddr];
`else
  // Output register holds its last word between pops and clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[raddr];
    end
  end
`endif

endmodule : sync_fifo_mem_non2n

// File: rtl/sync_fifo_non2n_param.sv
// Synchronous FIFO of arbitrary depth with count, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered.
module sync_fifo_non2n_param
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter  int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
  parameter  int AFULL_THRESH  = FIFO_DEPTH - 4,
  parameter  int AEMPTY_THRESH = 4,
  localparam int PTR_WIDTH     = clog2_width(FIFO_DEPTH),
  localparam int COUNT_WIDTH   = clog2_width(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic [DATA_WIDTH-1:0]  wdata,
  output logic                   full,
  output logic                   almost_full,
  input  logic                   r_en,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic                   rvalid,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow,
  output logic                   underflow
);

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_non2n_param: FIFO_DEPTH must be at least 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
    $error("sync_fifo_non2n_param: AFULL_THRESH must lie in 1..FIFO_DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_non2n_param: AEMPTY_THRESH must lie in 0..FIFO_DEPTH-1");
  end

  localparam logic [PTR_WIDTH-1:0]   LAST_PTR   = PTR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] DEPTH_CNT  = COUNT_WIDTH'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] AFULL_CNT  = COUNT_WIDTH'(AFULL_THRESH);
  localparam logic [COUNT_WIDTH-1:0] AEMPTY_CNT = COUNT_WIDTH'(AEMPTY_THRESH);

  logic [PTR_WIDTH-1:0] wptr;
  logic [PTR_WIDTH-1:0] rptr;
  logic                 wr_acc;
  logic                 rd_acc;
  fifo_op_e             op;

  // Status comes straight from the registered count.
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  // Full blocks writes even if a read pops the same cycle; empty blocks reads
  // even if a write lands the same cycle.
  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    op = OP_IDLE;
    if (wr_acc && rd_acc) begin
      op = OP_BOTH;
    end else if (wr_acc) begin
      op = OP_WRITE;
    end else if (rd_acc) begin
      op = OP_READ;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= (wptr == LAST_PTR) ? '0 : wptr + PTR_WIDTH'(1);
      end
      if (rd_acc) begin
        rptr <= (rptr == LAST_PTR) ? '0 : rptr + PTR_WIDTH'(1);
      end
      unique case (op)
        OP_WRITE: count <= count + COUNT_WIDTH'(1);
        OP_READ:  count <= count - COUNT_WIDTH'(1);
        default:  count <= count;
      endcase
      if (w_en && full) begin
        overflow <= 1'b1;
      end
      if (r_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Gating with rst keeps a request that coincides with reset out of memory.
  sync_fifo_mem_non2n #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk   (clk),
`ifndef SYNC_FIFO_FWFT_EN
    .rst   (rst),
    .rd_en (rd_acc && !rst),
`endif
    .wr_en (wr_acc && !rst),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign rvalid = !empty;
`else
  // rvalid marks the single cycle in which a freshly popped word sits on rdata.
  logic rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
    end
  end

  assign rvalid = rvalid_q;
`endif

endmodule : sync_fifo_non2n_param

// File: tb/tb_sync_fifo_non2n_param.sv
// Directed bench for sync_fifo_non2n_param at FIFO_DEPTH=5, AFULL=4, AEMPTY=1.
// Expectations follow SYNC_FIFO_FWFT_EN the same way the design does.
module tb_sync_fifo_non2n_param;

  localparam int DW = 8;
  localparam int DEPTH = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_en = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          r_en = 1'b0;
  logic          full;
  logic          almost_full;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          empty;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_non2n_param #(
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (DEPTH),
    .AFULL_THRESH  (4),
    .AEMPTY_THRESH (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .wdata        (wdata),
    .full         (full),
    .almost_full  (almost_full),
    .r_en         (r_en),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_aempty"}, 32'(almost_empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_udf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    // Reset
    step();
    step();
    rst = 1'b0;
    check_reset_state("rst");
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_rdata", 32'(rdata), 32'h0);
`endif

    // Fill 0x11..0x15
    for (int i = 0; i < 5; i++) begin
      w_en = 1'b1;
      wdata = 8'(8'h11 + i);
      step();
      check($sformatf("fill_count_%0d", i), 32'(count), 32'(i + 1));
      check($sformatf("fill_afull_%0d", i), 32'(almost_full), 32'((i + 1) >= 4));
      check($sformatf("fill_full_%0d", i), 32'(full), 32'((i + 1) == 5));
    end
    wdata = 8'h16;
    step();
    w_en = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd5);

`ifdef SYNC_FIFO_FWFT_EN
    // Drain: head is visible before each pop
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fwft_head_%0d", i), 32'(rdata), 32'(8'h11 + i));
      check($sformatf("fwft_rvalid_%0d", i), 32'(rvalid), 32'd1);
      r_en = 1'b1;
      step();
    end
    r_en = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_rvalid", 32'(rvalid), 32'd0);
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    check("udf_set", 32'(underflow), 32'd1);

    // Single write into empty falls through on the next cycle
    w_en = 1'b1;
    wdata = 8'hA5;
    step();
    w_en = 1'b0;
    check("fwft_a5_rvalid", 32'(rvalid), 32'd1);
    check("fwft_a5_rdata", 32'(rdata), 32'hA5);
    check("fwft_a5_count", 32'(count), 32'd1);
    step();
    check("fwft_a5_hold", 32'(rdata), 32'hA5);
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    check("fwft_a5_empty", 32'(empty), 32'd1);
    check("fwft_a5_rvalid_lo", 32'(rvalid), 32'd0);
`else
    // Drain: each word one cycle after its r_en
    r_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rd_rvalid_%0d", i), 32'(rvalid), 32'd1);
      check($sformatf("rd_data_%0d", i), 32'(rdata), 32'(8'h11 + i));
    end
    r_en = 1'b0;
    step();
    check("drain_rvalid_lo", 32'(rvalid), 32'd0);
    check("drain_hold", 32'(rdata), 32'h15);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_udf_clear", 32'(underflow), 32'd0);
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    check("udf_set", 32'(underflow), 32'd1);
    check("udf_rvalid", 32'(rvalid), 32'd0);
    check("udf_count", 32'(count), 32'd0);

    // Wrap: 7 write/read pairs carry both pointers through 4->0
    for (int i = 0; i < 7; i++) begin
      w_en = 1'b1;
      wdata = 8'(8'h30 + i);
      step();
      w_en = 1'b0;
      r_en = 1'b1;
      step();
      r_en = 1'b0;
      check($sformatf("wrap_data_%0d", i), 32'(rdata), 32'(8'h30 + i));
      check($sformatf("wrap_count_%0d", i), 32'(count), 32'd0);
    end

    // Simultaneous at count=3
    for (int i = 0; i < 3; i++) begin
      w_en = 1'b1;
      wdata = 8'(8'h41 + i);
      step();
    end
    check("sim3_pre", 32'(count), 32'd3);
    r_en = 1'b1;
    wdata = 8'h44;
    step();
    check("sim3_count_a", 32'(count), 32'd3);
    check("sim3_data_a", 32'(rdata), 32'h41);
    wdata = 8'h45;
    step();
    check("sim3_count_b", 32'(count), 32'd3);
    check("sim3_data_b", 32'(rdata), 32'h42);
    r_en = 1'b0;
    wdata = 8'h46;
    step();
    wdata = 8'h47;
    step();
    check("simfull_pre", 32'(count), 32'd5);

    // Simultaneous at full: write rejected, read accepted
    r_en = 1'b1;
    wdata = 8'h48;
    step();
    w_en = 1'b0;
    check("simfull_count", 32'(count), 32'd4);
    check("simfull_data", 32'(rdata), 32'h43);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("simfull_drain_%0d", i), 32'(rdata), 32'(8'h44 + i));
    end
    r_en = 1'b0;
    step();
    check("simfull_empty", 32'(empty), 32'd1);

    // Simultaneous at empty: read rejected, write accepted
    w_en = 1'b1;
    r_en = 1'b1;
    wdata = 8'h49;
    step();
    w_en = 1'b0;
    r_en = 1'b0;
    check("simempty_count", 32'(count), 32'd1);
    check("simempty_rvalid", 32'(rvalid), 32'd0);
    check("simempty_hold", 32'(rdata), 32'h47);
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    check("simempty_data", 32'(rdata), 32'h49);
    check("simempty_final", 32'(count), 32'd0);
`endif

    // Reset mid-operation with count=3; requests in the reset cycle are ignored
    for (int i = 0; i < 3; i++) begin
      w_en = 1'b1;
      wdata = 8'(8'h51 + i);
      step();
    end
    w_en = 1'b0;
    check("midrst_pre", 32'(count), 32'd3);
    rst = 1'b1;
    w_en = 1'b1;
    r_en = 1'b1;
    wdata = 8'h5A;
    step();
    rst = 1'b0;
    w_en = 1'b0;
    r_en = 1'b0;
    check_reset_state("midrst");
`ifndef SYNC_FIFO_FWFT_EN
    check("midrst_rdata", 32'(rdata), 32'h0);
`endif
    step();
    check("postrst_empty", 32'(empty), 32'd1);
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    check("postrst_udf", 32'(underflow), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sync_fifo_non2n_param

// File: doc/sync_fifo_non2n_param.md
SYNC_FIFO_NON2N_PARAM -- requirements
Module: sync_fifo_non2n_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 520, the number of entries; any integer >= 2, not limited to a power of two.
REQ-003 SHALL have parameter AFULL_THRESH, default FIFO_DEPTH-4, the count at or above which almost_full asserts.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 4, the count at or below which almost_empty asserts.
REQ-005 SHALL have derived constant PTR_WIDTH = clog2(FIFO_DEPTH) and COUNT_WIDTH = clog2(FIFO_DEPTH+1).
REQ-006 SHALL use one clock and a synchronous, active-high reset; the ports are named clk and rst.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 w_en  input  1  write request.
REQ-010 wdata  input  DATA_WIDTH  write data.
REQ-011 full  output  1  count == FIFO_DEPTH.
REQ-012 almost_full  output  1  count >= AFULL_THRESH.
REQ-013 r_en  input  1  read request (pop).
REQ-014 rdata  output  DATA_WIDTH  read data.
REQ-015 rvalid  output  1  rdata holds a valid popped word.
REQ-016 empty  output  1  count == 0.
REQ-017 almost_empty  output  1  count <= AEMPTY_THRESH.
REQ-018 count  output  COUNT_WIDTH  current occupancy.
REQ-019 overflow  output  1  sticky: a write was attempted while full.
REQ-020 underflow  output  1  sticky: a read was attempted while empty.

Function
REQ-021 A write SHALL be accepted iff w_en && !full; an accepted write stores wdata at wptr.
REQ-022 A read SHALL be accepted iff r_en && !empty; an accepted read advances rptr.
REQ-023 When full, a write SHALL be rejected even with a simultaneous accepted read.
REQ-024 When empty, a read SHALL be rejected even with a simultaneous write; that write SHALL still be accepted.
REQ-025 wptr and rptr SHALL count in binary and wrap explicitly from FIFO_DEPTH-1 to 0.
REQ-026 count SHALL go up by 1 on a write only, down by 1 on a read only, and stay the same on both or neither; it SHALL never exceed FIFO_DEPTH or go below 0.
REQ-027 full, empty, almost_full and almost_empty SHALL be derived combinationally from the registered count.
REQ-028 In standard mode, rdata SHALL be registered and valid one cycle after the accepted read; rvalid SHALL pulse high for that one cycle; otherwise rdata SHALL hold its last value.
REQ-029 overflow SHALL set on the edge where w_en && full; underflow SHALL set on the edge where r_en && empty; both SHALL clear only on rst.
REQ-030 Rejected requests SHALL NOT change the pointers, count or memory.

Reset
REQ-031 On rst, the block SHALL clear wptr, rptr and count to 0, set rdata to 0, set rvalid, overflow and underflow to 0, and therefore drive empty=1, almost_empty=1 and full=0.
REQ-032 A reset asserted mid-operation SHALL discard all contents; memory need not be cleared.
REQ-033 Requests present during the rst cycle SHALL be ignored.

Configuration
REQ-034 The macro SYNC_FIFO_FWFT_EN SHALL select the read mode.
REQ-035 With SYNC_FIFO_FWFT_EN defined (first-word-fall-through):
- rdata SHALL present the head entry whenever !empty, with zero read latency.
- rvalid SHALL equal !empty.
- r_en SHALL pop the presented word.
- The head SHALL appear on the cycle after the first write into an empty FIFO.
REQ-036 With SYNC_FIFO_FWFT_EN undefined, the block SHALL behave as in REQ-028.

Structure
REQ-037 Package sync_fifo_pkg SHALL hold the default DATA_WIDTH/FIFO_DEPTH constants and the clog2-based width helper.
REQ-038 Storage SHALL be the single sub-module sync_fifo_mem_non2n: FIFO_DEPTH x DATA_WIDTH, one synchronous write port and one read port (registered read in standard mode, asynchronous read in FWFT).
REQ-039 Elaboration SHALL fail if FIFO_DEPTH < 2, if AFULL_THRESH is outside 1..FIFO_DEPTH, or if AEMPTY_THRESH is outside 0..FIFO_DEPTH-1.

Verification (FIFO_DEPTH=5, AFULL_THRESH=4, AEMPTY_THRESH=1)
REQ-040 Reset, then write 0x11..0x15 on 5 cycles -> almost_full after the 4th write, full and count=5 after the 5th; a 6th write sets overflow=1 and count stays 5.
REQ-041 Standard mode: from full, read 5 times -> rdata 0x11..0x15 each one cycle after r_en with rvalid pulses; then empty=1; a further r_en sets underflow=1.
REQ-042 Wrap: 7 write/read pairs in a loop -> pointers wrap 4->0, data order preserved, count returns to 0.
REQ-043 Simultaneous w_en and r_en at count=3 -> count stays 3 and data stays in order; at full the write is rejected and count=4; at empty the read is rejected and count=1.
REQ-044 FWFT build: write 0xA5 into empty -> next cycle rvalid=1 and rdata=0xA5 with no r_en; r_en -> empty=1.
REQ-045 Assert rst with count=3 -> next cycle count=0, empty=1, rvalid=0 and flags cleared.
